// File: rtl/lm70_spi_responder.sv
// LM70-style SPI slave: returns a 16-bit temperature (or ID) word on SIO,
// then captures a 16-bit command that enters or leaves shutdown.
module lm70_spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] ID_WORD     = 16'h800F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs_n,
    input  logic               sck,
    input  logic               sio_in,
    output logic               sio_out,
    output logic               sio_oe,
    input  logic signed [10:0] temp_in,
    input  logic               temp_load,
    output logic               shutdown,
    output logic [15:0]        cmd_word,
    output logic               cmd_valid,
    output logic               frame_done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                   state, state_nxt;
    logic [SYNC_STAGES-1:0]   cs_sync, sck_sync, sio_sync;
    logic                     cs_d, sck_d;
    logic                     cs_s, sck_s, sio_s;
    logic                     cs_fall, cs_rise, sck_rise, sck_fall;
    logic                     last_bit, frame_end;
    logic [3:0]               bit_cnt;
    logic signed [10:0]       temp_reg, temp_pend;
    logic                     pend_vld;
    logic [15:0]              tx_sr, rx_sr, rx_next;

    function automatic logic [15:0] fmt_read_word(input logic signed [10:0] t,
                                                  input logic sd);
        return sd ? ID_WORD : {t, 3'b111, 2'b00};
    endfunction

    // Synchronizers start at 0 so a CS already low at reset release never
    // looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync  <= '0;
            sck_sync <= '0;
            sio_sync <= '0;
            cs_d     <= 1'b0;
            sck_d    <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            sio_sync <= {sio_sync[SYNC_STAGES-2:0], sio_in};
            cs_d     <= cs_s;
            sck_d    <= sck_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign sio_s     = sio_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sck_rise  = ~sck_d & sck_s;
    assign sck_fall  = sck_d & ~sck_s;
    assign last_bit  = (bit_cnt == 4'd15);
    assign frame_end = (state != IDLE) && cs_rise;
    assign rx_next   = {rx_sr[14:0], sio_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = READ;
            READ:    if (cs_rise) state_nxt = IDLE;
                     else if (sck_fall && last_bit) state_nxt = WRITE;
            WRITE:   if (cs_rise) state_nxt = IDLE;
                     else if (sck_rise && last_bit) state_nxt = DONE;
            DONE:    if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sio_out    <= 1'b0;
            sio_oe     <= 1'b0;
            shutdown   <= 1'b0;
            cmd_word   <= '0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            temp_reg   <= '0;
            pend_vld   <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (temp_load) begin
                if (state == IDLE) temp_reg <= temp_in;
                else               pend_vld <= 1'b1;
            end
            if (frame_end) begin
                sio_oe     <= 1'b0;
                frame_done <= 1'b1;
                pend_vld   <= 1'b0;
                if (temp_load)     temp_reg <= temp_in;
                else if (pend_vld) temp_reg <= temp_pend;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        sio_out <= fmt_read_word(temp_reg, shutdown) >> 15;
                        sio_oe  <= 1'b1;
                        bit_cnt <= '0;
                    end
                    READ: if (sck_fall) begin
                        if (last_bit) begin
                            sio_oe  <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            sio_out <= tx_sr[14];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    WRITE: if (sck_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            cmd_word  <= rx_next;
                            cmd_valid <= 1'b1;
                            if (rx_next[7:0] == 8'hFF)      shutdown <= 1'b1;
                            else if (rx_next[7:0] == 8'h00) shutdown <= 1'b0;
                        end
                    end
                    default: sio_oe <= 1'b0;
                endcase
            end
        end
    end

    // Shift registers and the pending temperature are pure data, qualified
    // by the control state above, so they carry no reset.
    always_ff @(posedge clk) begin
        if (temp_load && state != IDLE) temp_pend <= temp_in;
        if (state == IDLE && cs_fall)
            tx_sr <= fmt_read_word(temp_reg, shutdown);
        else if (state == READ && sck_fall && !cs_rise)
            tx_sr <= {tx_sr[14:0], 1'b0};
        if (state == IDLE && cs_fall)
            rx_sr <= '0;
        else if (state == WRITE && sck_rise && !cs_rise)
            rx_sr <= rx_next;
    end

endmodule

// File: tb/tb_lm70_spi_responder.sv
// Randomized bench for lm70_spi_responder: an SPI master drives frames and
// a behavioural sensor model predicts read words, commands and shutdown.
module tb_lm70_spi_responder;

    logic        clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, sck = 1'b0, sio_in = 1'b0;
    logic        temp_load = 1'b0;
    logic [10:0] temp_in = '0;
    logic        sio_out, sio_oe, shutdown, cmd_valid, frame_done;
    logic [15:0] cmd_word;

    lm70_spi_responder dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck), .sio_in(sio_in),
        .sio_out(sio_out), .sio_oe(sio_oe), .temp_in(temp_in),
        .temp_load(temp_load), .shutdown(shutdown), .cmd_word(cmd_word),
        .cmd_valid(cmd_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_pass = 0;
    int          cv_cnt = 0, fd_cnt = 0;
    logic [15:0] cv_last = '0;

    always @(negedge clk) begin
        if (cmd_valid) begin
            cv_cnt  = cv_cnt + 1;
            cv_last = cmd_word;
        end
        if (frame_done) fd_cnt = fd_cnt + 1;
    end

    // Sensor model state
    logic [10:0] m_temp = '0;
    logic        m_sd   = 1'b0;
    logic [15:0] m_cmd  = '0;

    function automatic logic [15:0] exp_word();
        if (m_sd) return 16'h800F;
        return 16'(m_temp) * 16'd32 + 16'd28;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_idle(input logic [10:0] v);
        temp_in = v; temp_load = 1'b1;
        clks(1);
        temp_load = 1'b0;
        clks(2);
        m_temp = v;
    endtask

    task automatic do_frame(input int nsck, input logic [15:0] wr, input int load_at,
                            input logic [10:0] load_val, output logic [15:0] rd);
        int hp, oe_bad, cv0, fd0;
        logic [15:0] exp_rd;
        hp = $urandom_range(4, 7);
        oe_bad = 0; cv0 = cv_cnt; fd0 = fd_cnt; exp_rd = exp_word(); rd = '0;
        cs_n = 1'b0;
        clks(hp);
        for (int i = 0; i < nsck; i++) begin
            sck = 1'b1;
            if (i < 16) begin
                rd[15-i] = sio_out;
                if (!sio_oe) oe_bad++;
            end
            clks(hp);
            sck = 1'b0;
            if (i >= 15 && i < 31) sio_in = wr[30-i];
            else                   sio_in = 1'($urandom);
            if (i == load_at) begin
                temp_in = load_val; temp_load = 1'b1;
                clks(1);
                temp_load = 1'b0;
                clks(hp - 1);
            end else clks(hp);
        end
        chk("oe_after_read", sio_oe, 0);
        chk("read_word", rd, exp_rd);
        chk("oe_during_read", oe_bad, 0);
        cs_n = 1'b1;
        clks(6);
        if (nsck >= 32) begin
            m_cmd = wr;
            if (wr[7:0] == 8'hFF)      m_sd = 1'b1;
            else if (wr[7:0] == 8'h00) m_sd = 1'b0;
        end
        if (load_at >= 0) m_temp = load_val;
        chk("frame_done_cnt", fd_cnt - fd0, 1);
        chk("cmd_valid_cnt", cv_cnt - cv0, (nsck >= 32) ? 1 : 0);
        if (nsck >= 32) chk("cmd_pulse_word", cv_last, wr);
        chk("cmd_word", cmd_word, m_cmd);
        chk("shutdown", shutdown, m_sd);
        chk("oe_idle", sio_oe, 0);
    endtask

    initial begin
        logic [15:0] rd;
        int          ns, la;
        logic [15:0] w;

        clks(3);
        chk("rst_sio_out", sio_out, 0);
        chk("rst_sio_oe", sio_oe, 0);
        chk("rst_shutdown", shutdown, 0);
        chk("rst_cmd_word", cmd_word, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        clks(4);

        load_idle(11'h064);
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_25c", rd, 16'h0C9C);
        load_idle(11'h7FF);
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_m025c", rd, 16'hFFFC);
        load_idle(11'h400);
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_min", rd, 16'h801C);

        do_frame(32, 16'h00FF, -1, '0, rd);
        chk("sd_set", shutdown, 1);
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_id", rd, 16'h800F);
        do_frame(32, 16'h1200, -1, '0, rd);
        chk("sd_clr", shutdown, 0);
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_after_clr", rd, 16'h801C);

        load_idle(11'h064);
        do_frame(16, 16'h0000, 5, 11'h0C8, rd);
        chk("rd_pend_cur", rd, 16'h0C9C);
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_pend_next", rd, 16'h191C);

        do_frame(24, 16'hA5FF, -1, '0, rd);
        chk("partial_sd", shutdown, 0);
        do_frame(40, 16'h34FF, -1, '0, rd);
        do_frame(40, 16'h5600, -1, '0, rd);

        // Reset in the middle of a read while in shutdown
        do_frame(32, 16'h00FF, -1, '0, rd);
        cs_n = 1'b0;
        clks(5);
        for (int i = 0; i < 5; i++) begin
            sck = 1'b1; clks(5);
            sck = 1'b0; clks(5);
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", sio_oe, 0);
        chk("mid_rst_out", sio_out, 0);
        chk("mid_rst_sd", shutdown, 0);
        clks(2);
        rst_n = 1'b1;
        cs_n  = 1'b1;
        clks(6);
        m_temp = '0; m_sd = 1'b0; m_cmd = '0;
        do_frame(16, 16'h0000, -1, '0, rd);
        chk("rd_after_rst", rd, 16'h001C);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1) load_idle(11'($urandom));
            case ($urandom_range(0, 3))
                0:       ns = 16;
                1:       ns = 24;
                2:       ns = 32;
                default: ns = 40;
            endcase
            w = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       w[7:0] = 8'hFF;
                1:       w[7:0] = 8'h00;
                default: ;
            endcase
            la = ($urandom_range(0, 2) == 0) ? $urandom_range(0, ns - 1) : -1;
            do_frame(ns, w, la, 11'($urandom), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lm70_spi_responder.md
# lm70_spi_responder

Synthesizable LM70-compatible SPI temperature-sensor responder: the slave end of the 3-wire CS/SCK/SIO link driven by the temperature monitor's SPI initiator. It serves a 16-bit temperature word on SIO during a CS-low frame, then accepts a 16-bit command word to enter or leave shutdown. It runs on a system clock faster than SCK, oversamples CS/SCK, and is used for FPGA bring-up and closed-loop verification of the monitor without a physical sensor.

## Interface
- SYNC_STAGES, 2: flops in each CS/SCK/SIO input synchronizer (min 2).
- ID_WORD, 16'h800F: word returned on reads while in shutdown.
- clk  in  1  system clock; must run at least 8x SCK frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- cs_n  in  1  SPI chip select from initiator, active low.
- sck  in  1  SPI clock from initiator, idle low.
- sio_in  in  1  SIO pad input (command bits from initiator).
- sio_out  out  1  SIO pad output data.
- sio_oe  out  1  SIO pad output enable, 1 = drive.
- temp_in  in  11  temperature, two's complement, 0.25 °C/LSB.
- temp_load  in  1  1-clk strobe capturing temp_in.
- shutdown  out  1  1 = shutdown mode.
- cmd_word  out  16  last complete command word received.
- cmd_valid  out  1  1-clk pulse when cmd_word updates.
- frame_done  out  1  1-clk pulse on CS rising edge ending any frame.

## Operation
- cs_n, sck, sio_in each pass through SYNC_STAGES flops; edges detected on synchronized values (cs_fall, cs_rise, sck_rise, sck_fall).
- Read word = {temp_reg[10:0], 3'b111, 2'b00} when shutdown=0; ID_WORD when shutdown=1. Captured into shift register tx_sr at cs_fall.
- temp_reg: on temp_load outside a frame (state IDLE) takes temp_in next clk; during a frame it is stored in a pending register and applied at cs_rise. Multiple loads in a frame: last wins.
- States: IDLE, READ, WRITE, DONE.
  - IDLE: sio_oe=0. cs_fall -> READ, sio_oe=1, sio_out=tx_sr[15], bit_cnt=0.
  - READ: on sck_fall, shift tx_sr left, sio_out=next bit, bit_cnt++. On the sck_fall following the 16th sck_rise, sio_oe=0 and -> WRITE, bit_cnt=0.
  - WRITE: on sck_rise shift sio_in into rx_sr LSB, bit_cnt++. After 16th sck_rise: cmd_word=rx_sr, cmd_valid pulse; low byte 8'hFF sets shutdown, 8'h00 clears it, other values no change; upper byte ignored; -> DONE.
  - DONE: further SCK edges ignored, sio_oe=0.
- cs_rise in any non-IDLE state: -> IDLE, sio_oe=0, frame_done pulse, pending temp applied. Partial command (<16 bits) discarded, shutdown unchanged.
- cs_fall while already in a frame cannot occur (cs_rise precedes); glitch narrower than SYNC_STAGES clk may be filtered, no requirement.
- Shutdown takes effect on the next frame's read word, never mid-frame.

## Timing
- Reset values: sio_out=0, sio_oe=0, shutdown=0, cmd_word=0, cmd_valid=0, frame_done=0, temp_reg=0, state IDLE.
- Input-to-action latency: SYNC_STAGES+1 clk from pad edge (3 clk default).
- sio_out/sio_oe update on the clk after edge detect; D15 valid 3 clk after CS pad falls; each next bit 3 clk after SCK pad falls, satisfying master sampling on SCK rise given SCK half-period >= 4 clk.
- cmd_valid asserts 1 clk after the 16th WRITE sck_rise detect; shutdown changes in the same cycle.
- frame_done and pending temp apply: same cycle, 1 clk after cs_rise detect.
- Reset asserted mid-frame: all outputs to reset values immediately (async); frame not resumed after release until next cs_fall.

## Test plan
- temp_load 11'h064 (25 °C), 16-SCK read frame -> master receives 16'h0C9C, sio_oe drops after bit 0, frame_done pulse at CS high.
- temp_in 11'h7FF (-0.25 °C) -> read 16'hFFFC; 11'h400 -> 16'h801C.
- 32-SCK frame, master writes 16'h00FF -> cmd_valid with cmd_word 16'h00FF, shutdown=1; next read returns 16'h800F; write 16'h1200 -> shutdown=0, following read returns temperature word.
- temp_load 11'h0C8 issued mid-frame with temp_reg 11'h064 -> current frame reads 16'h0C9C, next frame 16'h191C.
- CS raised after 8 write bits of 16'hxxFF -> no cmd_valid, shutdown stays 0, frame_done pulses; 40-SCK frame -> SCK beyond 32 ignored.
- rst_n low at bit 5 of read -> sio_oe=0, sio_out=0, shutdown=0 immediately; next frame after release reads 16'h001C.
